ps2_rx_frame: RTL

PS2_RX_FRAME -- requirements
Module: ps2_rx_frame

---
 rtl/ps2_pkg.sv | 16 +
 rtl/ps2_in_filter.sv | 49 ++++
 rtl/ps2_rx_frame.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
// Used by ps2_in_filter and ps2_rx_frame.
package ps2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_CHECK = 2'd2
   } ps2_state_t;

   localparam int PS2_FRAME_BITS  = 11;
   localparam int DEF_FIFO_DEPTH  = 4;
   localparam int DEF_FILTER_LEN  = 8;
   localparam int DEF_TIMEOUT_CYC = 20000;

endpackage

// File: rtl/ps2_in_filter.sv
// Two-flop synchronizer plus run-length glitch filter for the PS/2 clock line.
// Emits a one-cycle 'fall' strobe when the filtered level goes from 1 to 0.
module ps2_in_filter
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN = DEF_FILTER_LEN
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic fall
);

   localparam int CW = $clog2(FILTER_LEN + 1);

   logic          sync_p0;
   logic          sync_p1;
   logic          level;
   logic [CW-1:0] run_cnt;
   logic          accept;

   // The new level is taken on the FILTER_LEN-th consecutive differing sample.
   assign accept = (sync_p1 != level) && (run_cnt == CW'(FILTER_LEN - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_p0 <= 1'b1;
         sync_p1 <= 1'b1;
         level   <= 1'b1;
         run_cnt <= '0;
         fall    <= 1'b0;
      end else begin
         // stage p0 -> p1: metastability settling
         sync_p0 <= din;
         sync_p1 <= sync_p0;
         // filter stage
         fall    <= accept && !sync_p1;
         if (sync_p1 == level) begin
            run_cnt <= '0;
         end else if (accept) begin
            run_cnt <= '0;
            level   <= sync_p1;
         end else begin
            run_cnt <= run_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver with a show-ahead byte FIFO.
// Define PS2_RX_PARITY_CHECK_EN to reject frames whose data+parity is not odd.
module ps2_rx_frame
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
   parameter int FILTER_LEN  = DEF_FILTER_LEN,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic       Bus2IP_Clk,
   input  logic       Bus2IP_Reset,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   input  logic       rd_en,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   output logic [4:0] fifo_count,
   output logic       frame_err,
   output logic       ovf,
   input  logic       ovf_clr,
   output logic       irq
);

   localparam int         AW       = $clog2(FIFO_DEPTH);
   localparam int         TW       = $clog2(TIMEOUT_CYC + 1);
   localparam logic [3:0] LAST_BIT = 4'(PS2_FRAME_BITS - 2);
   localparam logic [4:0] DEPTH5   = 5'(FIFO_DEPTH);

   function automatic logic parity_ok(input logic [8:0] bits);
`ifdef PS2_RX_PARITY_CHECK_EN
      return ^bits;
`else
      // parity bit is captured but never rejects a frame
      return (^bits) | 1'b1;
`endif
   endfunction

   logic          strobe;
   logic          data_p0;
   logic          data_p1;
   ps2_state_t    state;
   ps2_state_t    state_nx;
   logic [3:0]    bit_cnt;
   logic [9:0]    shreg;
   logic [TW-1:0] tmo_cnt;
   logic          tmo_hit;
   logic          frame_ok;
   logic          push;
   logic          err;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [4:0]    count;
   logic          pop;
   logic          full;
   logic          wr;

   ps2_in_filter #(
      .FILTER_LEN (FILTER_LEN)
   ) u_clk_filt (
      .clk  (Bus2IP_Clk),
      .rst  (Bus2IP_Reset),
      .din  (ps2_clk_i),
      .fall (strobe)
   );

   assign tmo_hit  = (tmo_cnt == TW'(TIMEOUT_CYC - 1)) && !strobe;
   assign frame_ok = shreg[9] && parity_ok(shreg[8:0]);

   always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
      if (Bus2IP_Reset) state <= ST_IDLE;
      else              state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         ST_IDLE:  if (strobe && !data_p1) state_nx = ST_SHIFT;
         ST_SHIFT: begin
            if (strobe && (bit_cnt == LAST_BIT)) state_nx = ST_CHECK;
            else if (tmo_hit)                    state_nx = ST_IDLE;
         end
         ST_CHECK: state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      push = 1'b0;
      err  = 1'b0;
      case (state)
         ST_SHIFT: err = tmo_hit;
         ST_CHECK: begin
            push = frame_ok;
            err  = !frame_ok;
         end
         default: ;
      endcase
   end

   // data line: bare synchronizer; bit and timeout counters
   always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
      if (Bus2IP_Reset) begin
         data_p0   <= 1'b1;
         data_p1   <= 1'b1;
         bit_cnt   <= '0;
         tmo_cnt   <= '0;
         frame_err <= 1'b0;
      end else begin
         data_p0   <= ps2_data_i;
         data_p1   <= data_p0;
         frame_err <= err;
         if (state == ST_SHIFT) begin
            if (strobe) begin
               bit_cnt <= bit_cnt + 1'b1;
               tmo_cnt <= '0;
            end else begin
               tmo_cnt <= tmo_cnt + 1'b1;
            end
         end else begin
            bit_cnt <= '0;
            tmo_cnt <= '0;
         end
      end
   end

   // LSB-first shift: after ten strobes [7:0]=data, [8]=parity, [9]=stop
   always_ff @(posedge Bus2IP_Clk) begin
      if ((state == ST_SHIFT) && strobe) shreg <= {data_p1, shreg[9:1]};
   end

   assign pop  = rd_en && (count != 5'd0);
   assign full = (count == DEPTH5);
   assign wr   = push && (!full || pop);

   always_ff @(posedge Bus2IP_Clk) begin
      if (wr) mem[wr_ptr] <= shreg[7:0];
   end

   always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
      if (Bus2IP_Reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else begin
         if (wr)  wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({wr, pop})
            2'b10:   count <= count + 5'd1;
            2'b01:   count <= count - 5'd1;
            default: count <= count;
         endcase
         // a fresh overflow outranks a simultaneous clear
         if (push && full && !pop) ovf <= 1'b1;
         else if (ovf_clr)         ovf <= 1'b0;
      end
   end

   assign rd_valid   = (count != 5'd0);
   assign rd_data    = rd_valid ? mem[rd_ptr] : 8'h00;
   assign fifo_count = count;
   assign irq        = rd_valid;

endmodule
